// File: rtl/display_timings_prog.sv
// Runtime-programmable display timing generator.
// A timing set lives in shadow registers written over a small config bus. A COMMIT
// arms a swap that copies the shadow set into the live set exactly at frame wrap, so
// every frame is generated with one consistent timing set.
// Ports:
//   i_pixclk, i_rst      pixel clock, asynchronous active-high reset
//   i_cfg_we/addr/data   config write port (0-7 timing values, 8 polarity {V,H}, 9 COMMIT)
//   o_cfg_busy           commit pending, clears once the new timing is live
//   o_hs, o_vs           syncs with polarity applied
//   o_de                 display enable
//   o_line, o_frame      first-pixel-of-line / first-pixel-of-frame strobes
//   o_h, o_v             active pixel coordinates, 0 outside the active area
module display_timings_prog #(
  parameter int unsigned CORDW  = 12,
  parameter int unsigned H_RES  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter int unsigned H_POL  = 0,
  parameter int unsigned V_POL  = 0
) (
  input  logic             i_pixclk,
  input  logic             i_rst,
  input  logic             i_cfg_we,
  input  logic [3:0]       i_cfg_addr,
  input  logic [CORDW-1:0] i_cfg_data,
  output logic             o_cfg_busy,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_de,
  output logic             o_line,
  output logic             o_frame,
  output logic [CORDW-1:0] o_h,
  output logic [CORDW-1:0] o_v
);

  localparam int unsigned NREG = 8;

  typedef enum logic {S_IDLE, S_PENDING} state_t;

  // Register order matches the config address map: H_RES, H_FP, H_SYNC, H_BP, V_RES, V_FP, V_SYNC, V_BP.
  function automatic logic [CORDW-1:0] rst_val(input int unsigned idx);
    case (idx)
      0:       rst_val = CORDW'(H_RES);
      1:       rst_val = CORDW'(H_FP);
      2:       rst_val = CORDW'(H_SYNC);
      3:       rst_val = CORDW'(H_BP);
      4:       rst_val = CORDW'(V_RES);
      5:       rst_val = CORDW'(V_FP);
      6:       rst_val = CORDW'(V_SYNC);
      default: rst_val = CORDW'(V_BP);
    endcase
  endfunction

  state_t           state;
  logic [CORDW-1:0] live   [NREG];
  logic [CORDW-1:0] shadow [NREG];
  logic [1:0]       live_pol;
  logic [1:0]       shadow_pol;
  logic [CORDW-1:0] h_cnt;
  logic [CORDW-1:0] v_cnt;

  logic [CORDW-1:0] h_sync_beg, h_sync_end, h_act_beg, h_tot;
  logic [CORDW-1:0] v_sync_beg, v_sync_end, v_act_beg, v_tot;
  logic             h_last, v_last, h_act, v_act, h_in_sync, v_in_sync;

  // Region boundaries derived from the live timing set.
  always_comb begin
    h_sync_beg = live[1];
    h_sync_end = live[1] + live[2];
    h_act_beg  = live[1] + live[2] + live[3];
    h_tot      = live[0] + live[1] + live[2] + live[3];
    v_sync_beg = live[5];
    v_sync_end = live[5] + live[6];
    v_act_beg  = live[5] + live[6] + live[7];
    v_tot      = live[4] + live[5] + live[6] + live[7];
    h_last     = (h_cnt == h_tot - CORDW'(1));
    v_last     = (v_cnt == v_tot - CORDW'(1));
    h_act      = (h_cnt >= h_act_beg);
    v_act      = (v_cnt >= v_act_beg);
    h_in_sync  = (h_cnt >= h_sync_beg) && (h_cnt < h_sync_end);
    v_in_sync  = (v_cnt >= v_sync_beg) && (v_cnt < v_sync_end);
  end

  // Counters, registered decode and the commit state machine.
  always_ff @(posedge i_pixclk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      o_cfg_busy <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
        live[i]   <= rst_val(i);
        shadow[i] <= rst_val(i);
      end
      live_pol   <= {1'(V_POL), 1'(H_POL)};
      shadow_pol <= {1'(V_POL), 1'(H_POL)};
      h_cnt      <= '0;
      v_cnt      <= '0;
      o_hs       <= ~1'(H_POL);
      o_vs       <= ~1'(V_POL);
      o_de       <= 1'b0;
      o_line     <= 1'b0;
      o_frame    <= 1'b0;
      o_h        <= '0;
      o_v        <= '0;
    end else begin
      // Decode of the current count, visible one cycle later.
      o_hs    <= h_in_sync ? live_pol[0] : ~live_pol[0];
      o_vs    <= v_in_sync ? live_pol[1] : ~live_pol[1];
      o_de    <= h_act && v_act;
      o_line  <= (h_cnt == '0);
      o_frame <= (h_cnt == '0) && (v_cnt == '0);
      o_h     <= (h_act && v_act) ? h_cnt - h_act_beg : '0;
      o_v     <= (h_act && v_act) ? v_cnt - v_act_beg : '0;

      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + CORDW'(1);
      end else begin
        h_cnt <= h_cnt + CORDW'(1);
      end

      case (state)
        S_IDLE: begin
          if (i_cfg_we) begin
            if (i_cfg_addr < 4'd8) begin
              // Zero-length regions are not meaningful; clamp to 1.
              shadow[i_cfg_addr[2:0]] <= (i_cfg_data == '0) ? CORDW'(1) : i_cfg_data;
            end else if (i_cfg_addr == 4'd8) begin
              shadow_pol <= i_cfg_data[1:0];
            end else if (i_cfg_addr == 4'd9) begin
              state      <= S_PENDING;
              o_cfg_busy <= 1'b1;
            end
          end
        end
        S_PENDING: begin
          // Swap on the last pixel of the frame; counters restart at 0 for the new mode.
          if (h_last && v_last) begin
            for (int unsigned i = 0; i < NREG; i++) live[i] <= shadow[i];
            live_pol   <= shadow_pol;
            state      <= S_IDLE;
            o_cfg_busy <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_timings_prog.sv
// Self-checking bench for display_timings_prog with a tiny mode (H 4/1/2/1, V 3/1/1/1).
// A behavioural reference model predicts every output per cycle into a scoreboard queue.
module tb_display_timings_prog;

  typedef struct packed {
    logic        busy;
    logic        hs;
    logic        vs;
    logic        de;
    logic        line;
    logic        frame;
    logic [11:0] h;
    logic [11:0] v;
  } exp_t;

  logic        i_pixclk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_cfg_we = 1'b0;
  logic [3:0]  i_cfg_addr = 4'd0;
  logic [11:0] i_cfg_data = 12'd0;
  logic        o_cfg_busy, o_hs, o_vs, o_de, o_line, o_frame;
  logic [11:0] o_h, o_v;

  display_timings_prog #(
    .CORDW(12), .H_RES(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_RES(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(0), .V_POL(0)
  ) dut (
    .i_pixclk(i_pixclk), .i_rst(i_rst), .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr),
    .i_cfg_data(i_cfg_data), .o_cfg_busy(o_cfg_busy), .o_hs(o_hs), .o_vs(o_vs),
    .o_de(o_de), .o_line(o_line), .o_frame(o_frame), .o_h(o_h), .o_v(o_v)
  );

  always #5 i_pixclk = ~i_pixclk;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  // Reference model state; index 8 holds polarity {V,H}.
  int m_live[9];
  int m_sh[9];
  int m_hc, m_vc;
  bit m_busy;

  int cyc, de_cnt, max_h, max_v, frame_cnt, last_frame, period, hs_hi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_live = '{4, 1, 2, 1, 3, 1, 1, 1, 0};
    m_sh   = m_live;
    m_hc   = 0;
    m_vc   = 0;
    m_busy = 0;
    q.delete();
  endtask

  task automatic reset_stats();
    de_cnt = 0; max_h = 0; max_v = 0; frame_cnt = 0; last_frame = -1; period = 0; hs_hi = 0;
  endtask

  // Drive one cycle of config input, predict the outputs, compare after the edge.
  task automatic tick(input logic we, input logic [3:0] a, input logic [11:0] d);
    exp_t e, got;
    int   htot, vtot, hx, vy;
    bit   hw, vw, hpol, vpol;
    i_cfg_we = we; i_cfg_addr = a; i_cfg_data = d;
    htot = m_live[0] + m_live[1] + m_live[2] + m_live[3];
    vtot = m_live[4] + m_live[5] + m_live[6] + m_live[7];
    hx   = m_hc - (m_live[1] + m_live[2] + m_live[3]);
    vy   = m_vc - (m_live[5] + m_live[6] + m_live[7]);
    hpol = m_live[8][0];
    vpol = m_live[8][1];
    e.de    = (hx >= 0) && (vy >= 0);
    e.h     = e.de ? 12'(hx) : 12'd0;
    e.v     = e.de ? 12'(vy) : 12'd0;
    e.hs    = (m_hc >= m_live[1] && m_hc < m_live[1] + m_live[2]) ? hpol : ~hpol;
    e.vs    = (m_vc >= m_live[5] && m_vc < m_live[5] + m_live[6]) ? vpol : ~vpol;
    e.line  = (m_hc == 0);
    e.frame = (m_hc == 0) && (m_vc == 0);
    hw = (m_hc == htot - 1);
    vw = (m_vc == vtot - 1);
    if (m_busy) begin
      if (hw && vw) begin
        m_live = m_sh;
        m_busy = 0;
      end
    end else if (we) begin
      if (a < 8)       m_sh[a] = (d == 0) ? 1 : int'(d);
      else if (a == 8) m_sh[8] = int'(d[1:0]);
      else if (a == 9) m_busy = 1;
    end
    if (hw) begin
      m_hc = 0;
      m_vc = vw ? 0 : m_vc + 1;
    end else begin
      m_hc = m_hc + 1;
    end
    e.busy = m_busy;
    q.push_back(e);
    @(posedge i_pixclk);
    @(negedge i_pixclk);
    i_cfg_we = 1'b0;
    got = q.pop_front();
    chk("outs", 32'({o_cfg_busy, o_hs, o_vs, o_de, o_line, o_frame, o_h, o_v}), 32'(got));
    if (o_de) de_cnt++;
    if (o_hs) hs_hi++;
    if (int'(o_h) > max_h) max_h = int'(o_h);
    if (int'(o_v) > max_v) max_v = int'(o_v);
    if (o_frame) begin
      frame_cnt++;
      if (last_frame >= 0) period = cyc - last_frame;
      last_frame = cyc;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 4'd0, 12'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_cfg_busy && n < 500) begin
      tick(1'b0, 4'd0, 12'd0);
      n++;
    end
    chk(tag, 32'(o_cfg_busy), 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(tag, 32'({o_cfg_busy, o_hs, o_vs, o_de, o_line, o_frame, o_h, o_v}),
        32'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0}));
  endtask

  initial begin
    cyc = 0;
    model_reset();
    reset_stats();
    repeat (3) @(negedge i_pixclk);
    chk_reset_outs("reset_outs");

    // Release reset; the first edge presents count (0,0).
    i_rst = 1'b0;
    tick(1'b0, 4'd0, 12'd0);
    chk("first_frame", 32'(o_frame), 32'd1);
    chk("first_line", 32'(o_line), 32'd1);
    reset_stats();
    run(96);
    chk("base_de", de_cnt, 24);
    chk("base_maxh", max_h, 3);
    chk("base_maxv", max_v, 2);
    chk("base_frames", frame_cnt, 2);
    chk("base_period", period, 48);

    // H_RES=8 committed mid-frame; current frame keeps H_TOT 8.
    run(10);
    tick(1'b1, 4'd0, 12'd8);
    tick(1'b1, 4'd9, 12'd0);
    chk("busy_set", 32'(o_cfg_busy), 32'd1);
    wait_idle("busy_clear_hres");
    reset_stats();
    run(144);
    chk("hres_de", de_cnt, 48);
    chk("hres_maxh", max_h, 7);
    chk("hres_period", period, 72);
    chk("hres_hs_idle_high", hs_hi, 120);

    // POL=3, H_FP=0 (clamped to 1); writes while busy must be ignored.
    tick(1'b1, 4'd8, 12'd3);
    tick(1'b1, 4'd1, 12'd0);
    tick(1'b1, 4'd9, 12'd0);
    tick(1'b1, 4'd1, 12'd5);
    tick(1'b1, 4'd9, 12'd0);
    tick(1'b1, 4'd12, 12'd7);
    wait_idle("busy_clear_pol");
    reset_stats();
    run(144);
    chk("pol_period", period, 72);
    chk("pol_hs_pulse_high", hs_hi, 24);
    chk("pol_de", de_cnt, 48);

    // Asynchronous reset mid-line with a commit pending.
    tick(1'b1, 4'd0, 12'd2);
    tick(1'b1, 4'd9, 12'd0);
    run(5);
    chk("busy_before_rst", 32'(o_cfg_busy), 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    chk_reset_outs("midline_reset_outs");
    model_reset();
    @(negedge i_pixclk);
    i_rst = 1'b0;
    reset_stats();
    run(96);
    chk("rst_frames", frame_cnt, 2);
    chk("rst_period", period, 48);
    chk("rst_maxh", max_h, 3);
    chk("rst_de", de_cnt, 24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
